// File: rtl/recirc_active_ctrl_pkg.sv
// Shared types and defaults for the recirculation lock controller.
package recirc_active_ctrl_pkg;

  localparam int unsigned DataW          = 32;
  localparam int unsigned CntW           = 4;
  localparam logic [31:0] SyncWordDefault = 32'hBCBC_BCBC;

  // Encodings are visible on the debug state port.
  typedef enum logic [1:0] {
    StSearch  = 2'd0,
    StLocking = 2'd1,
    StActive  = 2'd2
  } state_e;

endpackage

// File: rtl/recirc_active_ctrl_if.sv
// Receive-stream and status bundle between the flop stage and the recirculation module.
interface recirc_active_ctrl_if;
  import recirc_active_ctrl_pkg::*;

  logic              enable;
  logic              valid_in;
  logic [DataW-1:0]  data_in;
  logic              active;
  logic              valid_out;
  logic [DataW-1:0]  data_out;
  logic [1:0]        state;
  logic [CntW-1:0]   sync_cnt;

  modport master (
    output enable, valid_in, data_in,
    input  active, valid_out, data_out, state, sync_cnt
  );

  modport slave (
    input  enable, valid_in, data_in,
    output active, valid_out, data_out, state, sync_cnt
  );

endinterface

// File: rtl/recirc_active_ctrl_sat_counter.sv
// Saturating up-counter; clr with inc loads 1 so a fresh run can start in one edge.
module recirc_active_ctrl_sat_counter #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [CntW-1:0] cnt_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? CntW'(1) : '0;
    end else if (inc_i && (cnt_q != {CntW{1'b1}})) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/recirc_active_ctrl.sv
// Lock FSM producing the 'active' route select, with data/valid re-timed by one cycle.
module recirc_active_ctrl
  import recirc_active_ctrl_pkg::*;
#(
  parameter logic [DataW-1:0] SyncWord  = SyncWordDefault,
  parameter int unsigned      SyncCount = 4,
  parameter int unsigned      LossCount = 8
) (
  input logic               clk_2f,
  input logic               reset_L,
  recirc_active_ctrl_if.slave bus
);

  state_e            state_d, state_q;
  logic              active_q;
  logic              valid_q;
  logic [DataW-1:0]  data_q;
  logic              sync_clr, sync_inc, loss_clr, loss_inc;
  logic [CntW-1:0]   sync_cnt, loss_cnt;
  logic              is_sync;

  assign is_sync = bus.valid_in && (bus.data_in == SyncWord);

  always_comb begin
    state_d  = state_q;
    sync_clr = 1'b0;
    sync_inc = 1'b0;
    loss_clr = 1'b0;
    loss_inc = 1'b0;
    if (!bus.enable) begin
      state_d  = StSearch;
      sync_clr = 1'b1;
      loss_clr = 1'b1;
    end else begin
      unique case (state_q)
        StSearch: begin
          loss_clr = 1'b1;
          sync_clr = 1'b1;
          if (is_sync) begin
            sync_inc = 1'b1;
            state_d  = (SyncCount == 1) ? StActive : StLocking;
          end
        end
        StLocking: begin
          loss_clr = 1'b1;
          if (is_sync) begin
            sync_inc = 1'b1;
            if (32'(sync_cnt) + 32'd1 >= SyncCount) state_d = StActive;
          end else if (bus.valid_in) begin
            sync_clr = 1'b1;
            state_d  = StSearch;
          end
        end
        StActive: begin
          if (bus.valid_in) begin
            loss_clr = 1'b1;
          end else if (32'(loss_cnt) + 32'd1 >= LossCount) begin
            loss_clr = 1'b1;
            sync_clr = 1'b1;
            state_d  = StSearch;
          end else begin
            loss_inc = 1'b1;
          end
        end
        default: begin
          state_d  = StSearch;
          sync_clr = 1'b1;
          loss_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= StSearch;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      // Registered from next-state so the lock-completing word leaves with active=1.
      active_q <= (state_d == StActive);
      valid_q  <= bus.valid_in;
      data_q   <= bus.data_in;
    end
  end

  recirc_active_ctrl_sat_counter #(.CntW(CntW)) u_sync_cnt (
    .clk_i  (clk_2f),
    .rst_ni (reset_L),
    .clr_i  (sync_clr),
    .inc_i  (sync_inc),
    .cnt_o  (sync_cnt)
  );

  recirc_active_ctrl_sat_counter #(.CntW(CntW)) u_loss_cnt (
    .clk_i  (clk_2f),
    .rst_ni (reset_L),
    .clr_i  (loss_clr),
    .inc_i  (loss_inc),
    .cnt_o  (loss_cnt)
  );

  assign bus.active    = active_q;
  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;
  assign bus.state     = state_q;
  assign bus.sync_cnt  = sync_cnt;

endmodule

// File: tb/tb_recirc_active_ctrl.sv
// Directed bench for recirc_active_ctrl: lock, abort, gaps, loss, enable and async reset.
module tb_recirc_active_ctrl;

  localparam logic [31:0] Sync = 32'hBCBC_BCBC;

  logic clk_2f  = 1'b0;
  logic reset_L = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  recirc_active_ctrl_if bus ();

  recirc_active_ctrl dut (
    .clk_2f  (clk_2f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one word, clock it in, sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [31:0] d);
    bus.valid_in = v;
    bus.data_in  = d;
    @(posedge clk_2f);
    #1;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    bus.enable = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in = '0;
    @(posedge clk_2f);
    #2;
    reset_L = 1'b1;
  endtask

  initial begin
    bus.enable   = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;

    // 1. Reset state, then lock on four sync words.
    do_reset();
    check("rst_active", 32'(bus.active), 32'd0);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_sync_cnt", 32'(bus.sync_cnt), 32'd0);
    check("rst_data_out", bus.data_out, 32'd0);
    step(1'b1, Sync);
    check("t1_cnt1", 32'(bus.sync_cnt), 32'd1);
    check("t1_state1", 32'(bus.state), 32'd1);
    step(1'b1, Sync);
    step(1'b1, Sync);
    check("t1_active3", 32'(bus.active), 32'd0);
    step(1'b1, Sync);
    check("t1_active4", 32'(bus.active), 32'd1);
    check("t1_data4", bus.data_out, Sync);
    check("t1_valid4", 32'(bus.valid_out), 32'd1);
    check("t1_cnt4", 32'(bus.sync_cnt), 32'd4);
    check("t1_state4", 32'(bus.state), 32'd2);

    // 2. Non-sync word during LOCKING aborts back to SEARCH.
    do_reset();
    step(1'b1, Sync);
    step(1'b1, Sync);
    step(1'b1, Sync);
    check("t2_cnt3", 32'(bus.sync_cnt), 32'd3);
    step(1'b1, 32'h0000_0001);
    check("t2_state", 32'(bus.state), 32'd0);
    check("t2_active", 32'(bus.active), 32'd0);
    check("t2_cnt", 32'(bus.sync_cnt), 32'd0);
    check("t2_data", bus.data_out, 32'h0000_0001);

    // 3. Gaps in LOCKING hold the count.
    do_reset();
    step(1'b1, Sync);
    step(1'b0, 32'h1111_1111);
    step(1'b0, 32'h2222_2222);
    check("t3_gap_state", 32'(bus.state), 32'd1);
    check("t3_gap_cnt", 32'(bus.sync_cnt), 32'd1);
    check("t3_gap_valid", 32'(bus.valid_out), 32'd0);
    check("t3_gap_data", bus.data_out, 32'h2222_2222);
    step(1'b1, Sync);
    step(1'b1, Sync);
    check("t3_active3", 32'(bus.active), 32'd0);
    step(1'b1, Sync);
    check("t3_active4", 32'(bus.active), 32'd1);

    // 4. Seven gaps tolerated, a valid word resets loss, eight gaps drop lock.
    for (int i = 0; i < 7; i++) step(1'b0, 32'(i));
    check("t4_after7", 32'(bus.active), 32'd1);
    step(1'b1, 32'hDEAD_BEEF);
    check("t4_valid_active", 32'(bus.active), 32'd1);
    check("t4_valid_data", bus.data_out, 32'hDEAD_BEEF);
    for (int i = 0; i < 7; i++) step(1'b0, 32'(i));
    check("t4_loss7", 32'(bus.active), 32'd1);
    step(1'b0, 32'h0);
    check("t4_loss8_active", 32'(bus.active), 32'd0);
    check("t4_loss8_state", 32'(bus.state), 32'd0);

    // 5. enable=0 in ACTIVE forces SEARCH while data keeps flowing.
    for (int i = 0; i < 4; i++) step(1'b1, Sync);
    check("t5_locked", 32'(bus.active), 32'd1);
    bus.enable = 1'b0;
    step(1'b1, 32'h1234_5678);
    check("t5_active", 32'(bus.active), 32'd0);
    check("t5_state", 32'(bus.state), 32'd0);
    check("t5_cnt", 32'(bus.sync_cnt), 32'd0);
    check("t5_data", bus.data_out, 32'h1234_5678);
    check("t5_valid", 32'(bus.valid_out), 32'd1);
    bus.enable = 1'b1;
    step(1'b1, 32'hCAFE_F00D);
    check("t5_data2", bus.data_out, 32'hCAFE_F00D);
    check("t5_state2", 32'(bus.state), 32'd0);

    // 6. Asynchronous reset mid-LOCKING clears outputs before any edge.
    step(1'b1, Sync);
    step(1'b1, Sync);
    check("t6_locking", 32'(bus.state), 32'd1);
    #2;
    reset_L = 1'b0;
    #1;
    check("t6_state", 32'(bus.state), 32'd0);
    check("t6_cnt", 32'(bus.sync_cnt), 32'd0);
    check("t6_valid", 32'(bus.valid_out), 32'd0);
    check("t6_data", bus.data_out, 32'd0);
    check("t6_active", 32'(bus.active), 32'd0);
    #3;
    reset_L = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
